// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types and sizes for the register-file arbiter.
// Contents: FSM state enum, register file address/data widths and depth.
// No ports; imported by regfile_arbiter.
package regfile_arb_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 8;
  localparam int NREGS  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports: req (N requests), ptr (index searched first) -> win (one-hot winner), vld (any winner).
// Search starts at ptr and wraps modulo N; purely combinational, no state.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          vld
);

  logic [PW-1:0] idx;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!vld && req[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one single-port 16x8 register file among N requesters
//   with round-robin grants and a req/done handshake; writes from read-only
//   requesters are suppressed and flagged on err.
// Ports: clk, clb (async active-high reset); per-requester req/we/addr/wdata in,
//   gnt/done/err out; shared rdata out; rf_load/rf_addr/rf_wdata drive the
//   register file, rf_rdata is its combinational read port.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] RO_MASK = 3'b100
) (
  input  logic                clk,
  input  logic                clb,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [REG_AW*N-1:0] addr,
  input  logic [REG_DW*N-1:0] wdata,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        done,
  output logic [N-1:0]        err,
  output logic [REG_DW-1:0]   rdata,
  output logic                rf_load,
  output logic [REG_AW-1:0]   rf_addr,
  output logic [REG_DW-1:0]   rf_wdata,
  input  logic [REG_DW-1:0]   rf_rdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_e              state_q, state_d;
  logic [PW-1:0]       sel_q, sel_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [N-1:0]        done_q, done_d;
  logic [N-1:0]        err_q, err_d;
  logic                rf_load_q, rf_load_d;
  logic [REG_AW-1:0]   rf_addr_q, rf_addr_d;
  logic [REG_DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [REG_DW-1:0]   rdata_q, rdata_d;
  // Write/read direction of the granted access, captured at grant time.
  logic                wr_q, wr_d;

  logic [N-1:0]        arb_req;
  logic [N-1:0]        win;
  logic                win_vld;
  logic [PW-1:0]       win_idx;
  logic                win_we;
  logic                win_ro;
  logic [REG_AW-1:0]   win_addr;
  logic [REG_DW-1:0]   win_wdata;
  logic                sel_ro;

  // gnt_q is only non-zero in ACCESS/DONE; in DONE it masks out the requester
  // just served so a held request waits for the following IDLE cycle.
  assign arb_req = req & ~gnt_q;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (ptr_q),
    .win (win),
    .vld (win_vld)
  );

  // Decode the one-hot winner into its index and request fields.
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx   = PW'(i);
        win_we    = we[i];
        win_addr  = addr[i*REG_AW +: REG_AW];
        win_wdata = wdata[i*REG_DW +: REG_DW];
      end
    end
  end

  assign win_ro = |(win & RO_MASK);
  assign sel_ro = |(gnt_q & RO_MASK);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    rf_load_d  = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    rdata_d    = rdata_q;
    wr_d       = wr_q;
    case (state_q)
      IDLE, DONE: begin
        if (win_vld) begin
          // Register file controls are set up on the grant edge so they are
          // valid for the whole ACCESS cycle.
          state_d    = ACCESS;
          sel_d      = win_idx;
          gnt_d      = win;
          wr_d       = win_we;
          rf_load_d  = win_we & ~win_ro;
          rf_addr_d  = win_addr;
          rf_wdata_d = win_wdata;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ptr_d   = (sel_q == PW'(N - 1)) ? '0 : sel_q + 1'b1;
        done_d  = gnt_q;
        err_d   = (wr_q && sel_ro) ? gnt_q : '0;
        if (!wr_q) begin
          rdata_d = rf_rdata;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clb) begin
    if (clb) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rf_load_q  <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rf_load_q  <= rf_load_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rdata_q    <= rdata_d;
      wr_q       <= wr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign rf_load  = rf_load_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed stimulus with a scoreboard for regfile_arbiter.
// Contains a behavioural 16x8 register file; expected completions are queued
// at issue time and checked by a monitor thread on every done pulse.
module tb_regfile_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           clb;
  logic [N-1:0]   req, we;
  logic [4*N-1:0] addr;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   gnt, done, err;
  logic [7:0]     rdata, rf_wdata, rf_rdata;
  logic           rf_load;
  logic [3:0]     rf_addr;

  logic [7:0] mem [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                           8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

  typedef struct {
    int         idx;
    logic       is_rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Expected gnt/done during continuous 3-way contention after reset release.
  logic [2:0] gtab [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
  logic [2:0] dtab [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_load) mem[rf_addr] <= rf_wdata;
  assign rf_rdata = mem[rf_addr];

  regfile_arbiter #(.N(N), .RO_MASK(3'b100)) dut (
    .clk      (clk),
    .clb      (clb),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .rf_load  (rf_load),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic rd, input logic [7:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.is_rd = rd; x.data = d; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic set_rq(input int i, input logic w, input logic [3:0] a, input logic [7:0] d);
    req[i]           = 1'b1;
    we[i]            = w;
    addr[i*4 +: 4]   = a;
    wdata[i*8 +: 8]  = d;
  endtask

  // Run until all requests are served and the arbiter is idle; requesters
  // drop req as soon as their done is seen.
  task automatic drain(input string name, output int loads);
    int cyc;
    cyc   = 0;
    loads = 0;
    while ((req != 0 || gnt != 0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rf_load) loads++;
      req = req & ~done;
    end
    if (cyc >= 40) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clb) begin
        if (|{gnt, done, err}) begin
          chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
          chk("err_without_done", 32'(err & ~done), 32'd0);
        end
        if (|done) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("sb_done_idx", 32'(done), 32'(1) << e.idx);
            chk("sb_err", 32'(err), e.err ? (32'(1) << e.idx) : 32'd0);
            if (e.is_rd) chk("sb_rdata", 32'(rdata), 32'(e.data));
          end
        end
      end
    end
  endtask

  initial begin
    int loads;
    clb = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    fork
      monitor();
    join_none

    @(negedge clk);
    chk("reset_outs", {gnt, done, err, rf_load, rf_addr, rf_wdata, rdata}, 32'd0);
    clb = 1'b0;
    set_rq(0, 1'b1, 4'd9, 8'h44);
    set_rq(1, 1'b0, 4'd2, 8'h00);
    set_rq(2, 1'b0, 4'd4, 8'h00);

    // Reset pulse in the middle of requester 0's write access.
    @(posedge clk); #2;
    chk("pre_reset_load", 32'(rf_load), 32'd1);
    chk("pre_reset_gnt", 32'(gnt), 32'b001);
    clb = 1'b1;
    #1;
    chk("async_reset_outs", {gnt, done, err, rf_load, rf_addr, rf_wdata, rdata}, 32'd0);
    @(negedge clk);
    clb = 1'b0;
    set_rq(0, 1'b0, 4'd1, 8'h00);

    // Continuous contention: grants rotate 0,1,2,0 with done every 2 cycles.
    push(0, 1'b1, 8'h11, 1'b0);
    push(1, 1'b1, 8'h22, 1'b0);
    push(2, 1'b1, 8'h44, 1'b0);
    push(0, 1'b1, 8'h11, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("cont_gnt_%0d", k), 32'(gnt), 32'(gtab[k]));
      chk($sformatf("cont_done_%0d", k), 32'(done), 32'(dtab[k]));
    end
    req = '0;
    drain("cont", loads);

    // Write reg 5 = 7F, then read it back with fixed 2-cycle latency.
    set_rq(0, 1'b1, 4'd5, 8'h7F);
    push(0, 1'b0, 8'h00, 1'b0);
    drain("wr5", loads);
    chk("wr5_load_cycles", 32'(loads), 32'd1);
    set_rq(1, 1'b0, 4'd5, 8'h00);
    push(1, 1'b1, 8'h7F, 1'b0);
    @(negedge clk);
    chk("rd5_gnt", 32'(gnt), 32'b010);
    @(negedge clk);
    chk("rd5_done_at_2", 32'(done), 32'b010);
    chk("rd5_rdata", 32'(rdata), 32'h7F);
    req = req & ~done;
    drain("rd5", loads);

    // Read-only requester 2 tries to overwrite reg 3 (holding 11).
    set_rq(0, 1'b1, 4'd3, 8'h11);
    push(0, 1'b0, 8'h00, 1'b0);
    drain("wr3", loads);
    set_rq(2, 1'b1, 4'd3, 8'h55);
    push(2, 1'b0, 8'h00, 1'b1);
    drain("ro_wr3", loads);
    chk("ro_load_cycles", 32'(loads), 32'd0);
    set_rq(1, 1'b0, 4'd3, 8'h00);
    push(1, 1'b1, 8'h11, 1'b0);
    drain("rd3", loads);

    // ptr is now 2: requests from 0 and 1 wrap to 0 first, then 1.
    set_rq(0, 1'b0, 4'd1, 8'h00);
    set_rq(1, 1'b0, 4'd2, 8'h00);
    push(0, 1'b1, 8'h11, 1'b0);
    push(1, 1'b1, 8'h22, 1'b0);
    @(negedge clk);
    chk("wrap_first_gnt", 32'(gnt), 32'b001);
    drain("wrap", loads);

    // Requester 1 drops req during its ACCESS cycle.
    set_rq(1, 1'b0, 4'd6, 8'h00);
    push(1, 1'b1, 8'h66, 1'b0);
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'b010);
    req[1] = 1'b0;
    @(negedge clk);
    chk("drop_done", 32'(done), 32'b010);
    chk("drop_rdata", 32'(rdata), 32'h66);
    @(negedge clk);
    chk("drop_idle_gnt", 32'(gnt), 32'b000);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
